// File: rtl/cpu_uart_mmio.sv
// UART register window on the CPU DMEM port: TX/RX byte FIFOs, status/control
// registers, and BRAM write suppression inside the window.
module cpu_uart_mmio #(
  parameter logic [15:0] MMIO_BASE  = 16'hFF00,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addrb,
  input  logic [3:0]  web_cpu,
  input  logic [31:0] dib,
  input  logic        rd_en,
  input  logic [31:0] dob_bram,
  output logic [31:0] dob_cpu,
  output logic [3:0]  web_bram,
  input  logic        rx_byte_done,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data
);

  localparam logic [FIFO_AW:0] CntFull = FIFO_DEPTH[FIFO_AW:0];

  logic [7:0]         rx_mem [FIFO_DEPTH];
  logic [7:0]         tx_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
  logic [FIFO_AW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic               ovr_q, ovr_d;
  logic               sel_q;
  logic [31:0]        rdata_q, rdata_d;
  logic               tx_start_q;
  logic [7:0]         tx_data_q;
  logic               guard_q, guard_d, gcnt_q, gcnt_d;

  logic       hit, cpu_wr;
  logic [1:0] off;
  logic       rx_empty, rx_full, tx_empty, tx_full;
  logic       rx_push, rx_pop, tx_push, tx_pop, ovr_set, ovr_clr;

  assign hit      = (addrb[15:8] == MMIO_BASE[15:8]);
  assign off      = addrb[3:2];
  assign web_bram = hit ? 4'b0000 : web_cpu;
  assign cpu_wr   = hit & (|web_cpu);

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CntFull);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == CntFull);

  assign rx_pop  = hit & rd_en & (off == 2'd0) & ~rx_empty;
  assign rx_push = rx_byte_done & (~rx_full | rx_pop);
  assign ovr_set = rx_byte_done & rx_full & ~rx_pop;
  assign ovr_clr = cpu_wr & (off == 2'd2) & dib[2];
  assign ovr_d   = ovr_set | (ovr_q & ~ovr_clr);

  // Drain is blocked while a start is in flight and until the UART drops tx_ready.
  assign tx_pop  = ~tx_empty & tx_ready & ~tx_start_q & ~guard_q;
  assign tx_push = cpu_wr & (off == 2'd0) & (~tx_full | tx_pop);

  assign rx_cnt_d = rx_cnt_q + (FIFO_AW+1)'(rx_push) - (FIFO_AW+1)'(rx_pop);
  assign tx_cnt_d = tx_cnt_q + (FIFO_AW+1)'(tx_push) - (FIFO_AW+1)'(tx_pop);

  always_comb begin
    rdata_d = rdata_q;
    if (hit && rd_en) begin
      case (off)
        2'd0:    rdata_d = {24'h0, rx_empty ? 8'h00 : rx_mem[rx_rp_q]};
        2'd1:    rdata_d = {28'h0, tx_empty, ovr_q, tx_full, ~rx_empty};
        default: rdata_d = 32'h0;
      endcase
    end
  end

  always_comb begin
    guard_d = guard_q;
    gcnt_d  = gcnt_q;
    if (tx_start_q) begin
      guard_d = 1'b1;
      gcnt_d  = 1'b0;
    end else if (guard_q) begin
      if (!tx_ready || gcnt_q) begin
        guard_d = 1'b0;
      end else begin
        gcnt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      ovr_q      <= 1'b0;
      sel_q      <= 1'b0;
      rdata_q    <= 32'h0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      guard_q    <= 1'b0;
      gcnt_q     <= 1'b0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      ovr_q      <= ovr_d;
      sel_q      <= hit & rd_en;
      rdata_q    <= rdata_d;
      tx_start_q <= tx_pop;
      if (tx_pop) tx_data_q <= tx_mem[tx_rp_q];
      guard_q    <= guard_d;
      gcnt_q     <= gcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q] <= rx_data;
    if (tx_push) tx_mem[tx_wp_q] <= dib[7:0];
  end

  assign dob_cpu  = sel_q ? rdata_q : dob_bram;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_cpu_uart_mmio.sv
// Directed bench for cpu_uart_mmio with a simple UART transmitter model.
module tb_cpu_uart_mmio;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addrb;
  logic [3:0]  web_cpu;
  logic [31:0] dib;
  logic        rd_en;
  logic [31:0] dob_bram;
  logic [31:0] dob_cpu;
  logic [3:0]  web_bram;
  logic        rx_byte_done;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;

  int n_checks = 0;
  int n_errors = 0;

  logic       uart_en = 1'b1;
  int         busy = 0;
  int         tx_cnt = 0;
  logic [7:0] tx_bytes [4];

  localparam logic [31:0] Bram = 32'hDEAD_BEEF;

  cpu_uart_mmio #(.MMIO_BASE(16'hFF00), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addrb        (addrb),
    .web_cpu      (web_cpu),
    .dib          (dib),
    .rd_en        (rd_en),
    .dob_bram     (dob_bram),
    .dob_cpu      (dob_cpu),
    .web_bram     (web_bram),
    .rx_byte_done (rx_byte_done),
    .rx_data      (rx_data),
    .tx_ready     (tx_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data)
  );

  always #5 clk = ~clk;

  // UART model: goes busy for 10 cycles after each start.
  assign tx_ready = uart_en && (busy == 0);
  always @(negedge clk) begin
    if (tx_start) begin
      if (tx_cnt < 4) tx_bytes[tx_cnt] <= tx_data;
      tx_cnt <= tx_cnt + 1;
      busy   <= 10;
    end else if (busy != 0) begin
      busy <= busy - 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic cpu_wr(input logic [15:0] a, input logic [31:0] d, input string tag);
    addrb   = a;
    web_cpu = 4'hF;
    dib     = d;
    #1;
    check_eq(tag, {28'h0, web_bram}, (a[15:8] == 8'hFF) ? 32'h0 : 32'hF);
    @(negedge clk);
    web_cpu = 4'h0;
    addrb   = 16'h0000;
  endtask

  task automatic cpu_rd(input logic [15:0] a, input logic [31:0] exp, input string tag);
    addrb = a;
    rd_en = 1'b1;
    @(negedge clk);
    check_eq(tag, dob_cpu, exp);
    rd_en = 1'b0;
    addrb = 16'h0000;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_byte_done = 1'b1;
    rx_data      = b;
    @(negedge clk);
    rx_byte_done = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    addrb        = 16'h0000;
    web_cpu      = 4'h0;
    dib          = 32'h0;
    rd_en        = 1'b0;
    dob_bram     = Bram;
    rx_byte_done = 1'b0;
    rx_data      = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_dob", dob_cpu, Bram);
    check_eq("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check_eq("rst_tx_data", {24'h0, tx_data}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_rd(16'hFF04, 32'h8, "rst_status");

    // TX of two bytes
    cpu_wr(16'hFF00, 32'h41, "tx_web0");
    cpu_wr(16'hFF00, 32'h42, "tx_web1");
    repeat (40) @(negedge clk);
    check_eq("tx_count", tx_cnt, 2);
    check_eq("tx_byte0", {24'h0, tx_bytes[0]}, 32'h41);
    check_eq("tx_byte1", {24'h0, tx_bytes[1]}, 32'h42);

    // Single RX byte
    rx_push(8'h5A);
    cpu_rd(16'hFF04, 32'h9, "rx_status1");
    cpu_rd(16'hFF00, 32'h5A, "rx_data1");
    cpu_rd(16'hFF04, 32'h8, "rx_status2");
    cpu_rd(16'hFF00, 32'h0, "rx_empty_rd");

    // Overrun
    for (int i = 0; i < 17; i++) rx_push(8'(i));
    cpu_rd(16'hFF04, 32'hD, "ovr_status");
    for (int i = 0; i < 16; i++) cpu_rd(16'hFF00, 32'(i), "ovr_data");
    cpu_rd(16'hFF04, 32'hC, "ovr_sticky");
    cpu_wr(16'hFF08, 32'h4, "ctrl_web");
    cpu_rd(16'hFF04, 32'h8, "ovr_clear");

    // Outside the window
    cpu_wr(16'h0100, 32'h77, "out_web");
    cpu_rd(16'h0100, Bram, "out_rd");
    cpu_rd(16'hFF04, 32'h8, "out_status");
    cpu_rd(16'hFF0C, 32'h0, "rsvd_rd");

    // Full RX FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) rx_push(8'(8'h20 + i));
    rx_byte_done = 1'b1;
    rx_data      = 8'h30;
    cpu_rd(16'hFF00, 32'h20, "full_pp_data");
    rx_byte_done = 1'b0;
    cpu_rd(16'hFF04, 32'h9, "full_pp_status");
    for (int i = 1; i < 16; i++) cpu_rd(16'hFF00, 32'(8'h20 + i), "full_pp_drain");
    cpu_rd(16'hFF00, 32'h30, "full_pp_last");
    cpu_rd(16'hFF04, 32'h8, "full_pp_empty");

    // Reset with TX bytes queued and a register read in flight
    uart_en = 1'b0;
    for (int i = 0; i < 5; i++) cpu_wr(16'hFF00, 32'(8'h60 + i), "q_web");
    cpu_rd(16'hFF04, 32'h0, "q_status");
    addrb = 16'hFF04;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    check_eq("pre_rst_sel", dob_cpu, 32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_dob", dob_cpu, Bram);
    check_eq("mid_rst_start", {31'h0, tx_start}, 32'h0);
    check_eq("mid_rst_data", {24'h0, tx_data}, 32'h0);
    rd_en = 1'b0;
    addrb = 16'h0000;
    @(negedge clk);
    rst_n   = 1'b1;
    uart_en = 1'b1;
    repeat (5) @(negedge clk);
    cpu_rd(16'hFF04, 32'h8, "post_rst_status");
    check_eq("post_rst_txcnt", tx_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
